// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity frame checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } pfc_state_t;

    // Increment v, sticking at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/xor_tree.sv
// Combinational XOR reduction of a WIDTH-bit word.
module xor_tree #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic             y
);

    assign y = ^a;

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming multi-beat parity checker with valid/ready handshakes and saturating totals.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned BEAT_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    input  logic              in_par,
    input  logic              odd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_parity,
    output logic              out_error,
    output logic [BEAT_W-1:0] out_beats,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  err_count
);

    pfc_state_t        state;
    logic              acc;
    logic              mode_q;
    logic [BEAT_W-1:0] beats;

    logic              beat_par_c;
    logic              accept_c;
    logic              acc_next_c;
    logic              mode_next_c;
    logic              parity_next_c;
    logic [BEAT_W-1:0] beats_next_c;

    xor_tree #(.WIDTH(WIDTH)) u_xor_tree (
        .a (in_data),
        .y (beat_par_c)
    );

    // Frame accumulation: the first beat of a frame restarts the accumulator and latches the mode.
    always_comb begin
        accept_c      = in_valid && in_ready;
        acc_next_c    = acc ^ beat_par_c;
        mode_next_c   = mode_q;
        beats_next_c  = BEAT_W'(sat_inc(32'(beats), BEAT_W));
        if (state == IDLE) begin
            acc_next_c   = beat_par_c;
            mode_next_c  = odd_mode;
            beats_next_c = BEAT_W'(1);
        end
        parity_next_c = acc_next_c ^ mode_next_c;
    end

    // in_ready/out_valid are kept as flops alongside the state so neither depends on out_ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= 1'b0;
            mode_q      <= 1'b0;
            beats       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_parity  <= 1'b0;
            out_error   <= 1'b0;
            out_beats   <= '0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept_c) begin
                        acc    <= acc_next_c;
                        mode_q <= mode_next_c;
                        beats  <= beats_next_c;
                        if (in_last) begin
                            state      <= HOLD;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            out_parity <= parity_next_c;
                            out_error  <= parity_next_c ^ in_par;
                            out_beats  <= beats_next_c;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        in_ready    <= 1'b1;
                        out_valid   <= 1'b0;
                        frame_count <= CNT_W'(sat_inc(32'(frame_count), CNT_W));
                        if (out_error) begin
                            err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench: two checker instances (default and narrow counters) against a frame-level model.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       in_par;
    logic       odd_mode;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_out_parity, a_out_error;
    logic [7:0]  a_out_beats;
    logic [15:0] a_frame_count, a_err_count;
    logic        b_in_ready, b_out_valid, b_out_parity, b_out_error;
    logic [1:0]  b_out_beats;
    logic [1:0]  b_frame_count, b_err_count;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference model
    bit f_open = 0;
    bit f_mode;
    int f_ones, f_n;
    bit exp_par, exp_err;
    int exp_n;
    int m_frames = 0, m_errs = 0;
    bit keep_valid = 0;
    bit count_bubbles = 0;
    int bubble_cnt = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.WIDTH(4), .BEAT_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .in_par(in_par), .odd_mode(odd_mode),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_parity(a_out_parity),
        .out_error(a_out_error), .out_beats(a_out_beats),
        .frame_count(a_frame_count), .err_count(a_err_count)
    );

    parity_frame_checker #(.WIDTH(4), .BEAT_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .in_par(in_par), .odd_mode(odd_mode),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_parity(b_out_parity),
        .out_error(b_out_error), .out_beats(b_out_beats),
        .frame_count(b_frame_count), .err_count(b_err_count)
    );

    always @(negedge clk) begin
        if (count_bubbles && !a_in_ready) bubble_cnt++;
    end

    function automatic int smin(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_totals(input string tag);
        chk({tag, "_a_frames"}, 32'(a_frame_count), 32'(smin(m_frames, 65535)));
        chk({tag, "_a_errs"},   32'(a_err_count),   32'(smin(m_errs, 65535)));
        chk({tag, "_b_frames"}, 32'(b_frame_count), 32'(smin(m_frames, 3)));
        chk({tag, "_b_errs"},   32'(b_err_count),   32'(smin(m_errs, 3)));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        f_open   = 0;
        m_frames = 0;
        m_errs   = 0;
        chk("rst_a_in_ready",  32'(a_in_ready),   32'd1);
        chk("rst_a_out_valid", 32'(a_out_valid),  32'd0);
        chk("rst_a_parity",    32'(a_out_parity), 32'd0);
        chk("rst_a_error",     32'(a_out_error),  32'd0);
        chk("rst_a_beats",     32'(a_out_beats),  32'd0);
        chk("rst_b_in_ready",  32'(b_in_ready),   32'd1);
        chk("rst_b_out_valid", 32'(b_out_valid),  32'd0);
        chk("rst_b_beats",     32'(b_out_beats),  32'd0);
        chk_totals("rst");
    endtask

    // Present one beat (called at a negedge) and wait until both instances accept it.
    task automatic beat(input logic [3:0] d, input logic last, input logic par, input logic mode);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_par   = par;
        odd_mode = mode;
        while (!(a_in_ready && b_in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        if (!f_open) begin
            f_open = 1;
            f_mode = mode;
            f_ones = 0;
            f_n    = 0;
        end
        f_ones += $countones(d);
        f_n++;
        if (last) begin
            exp_par = f_mode ^ (f_ones % 2 == 1);
            exp_err = exp_par ^ par;
            exp_n   = f_n;
            f_open  = 0;
        end
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Idle cycles inside a frame; odd_mode and data wiggle to prove they are ignored.
    task automatic gap(input int k);
        in_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            in_data  = 4'($urandom);
            odd_mode = 1'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
        end
    endtask

    // Check the pending result for `hold` stalled cycles, then complete the handshake.
    task automatic result(input string tag, input int hold);
        for (int i = 0; i <= hold; i++) begin
            chk({tag, "_a_valid"},  32'(a_out_valid),  32'd1);
            chk({tag, "_a_ready"},  32'(a_in_ready),   32'd0);
            chk({tag, "_a_parity"}, 32'(a_out_parity), 32'(exp_par));
            chk({tag, "_a_error"},  32'(a_out_error),  32'(exp_err));
            chk({tag, "_a_beats"},  32'(a_out_beats),  32'(smin(exp_n, 255)));
            chk({tag, "_b_valid"},  32'(b_out_valid),  32'd1);
            chk({tag, "_b_parity"}, 32'(b_out_parity), 32'(exp_par));
            chk({tag, "_b_beats"},  32'(b_out_beats),  32'(smin(exp_n, 3)));
            if (i < hold) begin
                chk({tag, "_hold_totals"}, 32'(a_frame_count), 32'(smin(m_frames, 65535)));
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        m_frames++;
        if (exp_err) m_errs++;
        @(negedge clk);
        if (!keep_valid) out_ready = 1'b0;
        chk({tag, "_post_a_valid"}, 32'(a_out_valid), 32'd0);
        chk({tag, "_post_a_ready"}, 32'(a_in_ready),  32'd1);
        chk({tag, "_post_b_ready"}, 32'(b_in_ready),  32'd1);
        chk_totals({tag, "_post"});
    endtask

    initial begin
        int len;
        logic m;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_par    = 1'b0;
        odd_mode  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Single-beat even frame
        beat(4'b1011, 1'b1, 1'b1, 1'b0);
        result("t1", 0);

        // Three-beat odd frame, consumer stalls for 5 cycles
        beat(4'b0001, 1'b0, 1'b0, 1'b1);
        beat(4'b0011, 1'b0, 1'b0, 1'b0);
        beat(4'b1111, 1'b1, 1'b0, 1'b0);
        result("t2", 5);

        // Error frame from a clean reset
        do_reset();
        beat(4'b0110, 1'b1, 1'b1, 1'b0);
        result("t3", 1);

        // Reset mid-frame discards the partial frame
        beat(4'b0111, 1'b0, 1'b0, 1'b1);
        beat(4'b0101, 1'b0, 1'b0, 1'b1);
        do_reset();
        beat(4'b1000, 1'b1, 1'b1, 1'b0);
        result("t4", 0);

        // Back-to-back frames with in_valid and out_ready held high
        do_reset();
        keep_valid    = 1;
        out_ready     = 1'b1;
        bubble_cnt    = 0;
        count_bubbles = 1;
        for (int f = 0; f < 10; f++) begin
            len = (f % 3) + 1;
            for (int b = 0; b < len; b++)
                beat(4'($urandom), 1'(b == len - 1), 1'($urandom), 1'($urandom));
            result("t5", 0);
        end
        count_bubbles = 0;
        keep_valid    = 0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        chk("t5_bubbles", 32'(bubble_cnt), 32'd10);
        chk("t5_frames",  32'(a_frame_count), 32'd10);

        // Saturation: long frame and repeated error frames
        do_reset();
        for (int b = 0; b < 6; b++) beat(4'($urandom), 1'(b == 5), 1'b0, 1'b0);
        result("t6_long", 0);
        for (int f = 0; f < 5; f++) begin
            in_data = 4'($urandom);
            beat(in_data, 1'b1, ~(^in_data), 1'b0);
            result("t6_err", 0);
        end
        chk("t6_b_err_sat", 32'(b_err_count), 32'd3);

        // Randomized frames with idle gaps and stalls
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 7);
            m   = 1'($urandom);
            for (int b = 0; b < len; b++) begin
                if (b > 0) gap($urandom_range(0, 2));
                beat(4'($urandom), 1'(b == len - 1), 1'($urandom), (b == 0) ? m : 1'($urandom));
            end
            result("rnd", $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
